// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core tile scheduler.
//   - tile geometry defaults (N_GROUP x N_UNIT outputs, N_MUL-deep K slice)
//   - operand/accumulator widths of the core datapath
//   - scheduler state encoding
//   - sparse_mode encodings driven onto core in_valid
package core_pkg;

  localparam int N_GROUP = 4;   // tile_M
  localparam int N_UNIT  = 4;   // tile_N
  localparam int N_MUL   = 4;   // tile_K per beat
  localparam int DW_MUL  = 8;   // multiplier operand width
  localparam int DW_ADD  = 20;  // accumulator width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } sched_state_e;

  localparam logic [1:0] SPARSE_DENSE = 2'd0;
  localparam logic [1:0] SPARSE_2OF4  = 2'd1;
  localparam logic [1:0] SPARSE_1OF4  = 2'd2;
  localparam logic [1:0] SPARSE_RSVD  = 2'd3;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/core_tile_sched_cnt.sv
// sched_cnt: loadable up-counter with terminal-count flag.
// Ports:
//   i_clk, i_rst_n   clock / async active-low reset
//   i_load           load i_load_val (wins over i_inc)
//   i_load_val       load value
//   i_inc            increment by one
//   i_term           terminal value
//   o_cnt            current count
//   o_tc             o_cnt == i_term
module sched_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_inc)  r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/core_tile_sched.sv
// core_tile_sched: sequences one output tile of the core dot-product array
// across a programmable number of K beats.
//   IDLE -> CLEAR (one accumulator-clear cycle) -> FETCH (one operand
//   request per beat, stalled by grant) -> DRAIN (PIPE_LAT cycles of core
//   pipeline) -> OUT (valid/ready handshake) -> IDLE with a done pulse.
// Ports:
//   i_clk, i_rst_n                 clock / async active-low reset
//   i_start, i_k_tiles, i_base_a,
//   i_base_b, i_sparse_mode        tile command, latched on accepted start
//   o_busy, o_done                 tile in flight / end-of-tile pulse
//   o_rd_req, o_rd_addr_a/b, i_rd_gnt   operand fetch interface
//   o_core_enable, o_core_in_valid,
//   o_core_clear                   core control
//   o_out_valid, i_out_ready       finished-tile handshake
//   o_stall_cnt                    only with CORE_SCHED_PERF_EN: fetch-stall
//                                  plus output-backpressure cycles, saturating
module core_tile_sched
  import core_pkg::*;
#(
  parameter int DW_CNT   = 8,
  parameter int AW       = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DW_CNT-1:0] i_k_tiles,
  input  logic [AW-1:0]     i_base_a,
  input  logic [AW-1:0]     i_base_b,
  input  logic [1:0]        i_sparse_mode,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_req,
  output logic [AW-1:0]     o_rd_addr_a,
  output logic [AW-1:0]     o_rd_addr_b,
  input  logic              i_rd_gnt,
  output logic              o_core_enable,
  output logic [1:0]        o_core_in_valid,
  output logic              o_core_clear,
  output logic              o_out_valid,
  input  logic              i_out_ready
`ifdef CORE_SCHED_PERF_EN
  ,
  output logic [15:0]       o_stall_cnt
`endif
);

  localparam int DRW = cnt_w(PIPE_LAT);

  sched_state_e      r_state;
  logic              r_busy, r_done, r_req, r_en, r_clear, r_ov;
  logic [DW_CNT-1:0] r_k;
  logic [AW-1:0]     r_base_a, r_base_b;
  logic [1:0]        r_sparse;

  logic              w_accept, w_grant, w_last_grant;
  logic [DW_CNT-1:0] w_beat, w_beat_term;
  logic              w_beat_tc, w_drain_tc;
  logic [DRW-1:0]    w_drain_cnt_unused;

  assign w_accept     = (r_state == ST_IDLE) && i_start && (i_k_tiles != '0);
  assign w_grant      = r_req & i_rd_gnt;
  assign w_last_grant = w_grant & w_beat_tc;
  assign w_beat_term  = r_k - DW_CNT'(1);   // r_k is never 0 while fetching

  // Beat index: cleared on start, advances on each accepted fetch.
  sched_cnt #(.W(DW_CNT)) u_beat (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_accept),
    .i_load_val ('0),
    .i_inc      (w_grant),
    .i_term     (w_beat_term),
    .o_cnt      (w_beat),
    .o_tc       (w_beat_tc)
  );

  // Drain: loaded on the last grant, so DRAIN's first cycle coincides with
  // the final core_enable and OUT starts PIPE_LAT cycles after that pulse.
  sched_cnt #(.W(DRW)) u_drain (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_last_grant),
    .i_load_val ('0),
    .i_inc      (r_state == ST_DRAIN),
    .i_term     (DRW'(PIPE_LAT - 1)),
    .o_cnt      (w_drain_cnt_unused),
    .o_tc       (w_drain_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_req    <= 1'b0;
      r_en     <= 1'b0;
      r_clear  <= 1'b0;
      r_ov     <= 1'b0;
      r_k      <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_sparse <= SPARSE_DENSE;
    end else begin
      r_done  <= 1'b0;
      r_clear <= 1'b0;
      r_en    <= w_grant;   // data lands in the core the cycle after grant
      case (r_state)
        ST_IDLE: if (i_start) begin
          if (w_accept) begin
            r_state  <= ST_CLEAR;
            r_busy   <= 1'b1;
            r_clear  <= 1'b1;
            r_k      <= i_k_tiles;
            r_base_a <= i_base_a;
            r_base_b <= i_base_b;
            r_sparse <= i_sparse_mode;
          end else begin
            r_done   <= 1'b1;   // empty tile: complete immediately
          end
        end
        ST_CLEAR: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: if (w_last_grant) begin
          r_state <= ST_DRAIN;
          r_req   <= 1'b0;
        end
        ST_DRAIN: if (w_drain_tc) begin
          r_state <= ST_OUT;
          r_ov    <= 1'b1;
        end
        ST_OUT: if (i_out_ready) begin
          r_state <= ST_IDLE;
          r_ov    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_rd_req        = r_req;
  assign o_rd_addr_a     = r_base_a + AW'(w_beat);   // wraps mod 2^AW
  assign o_rd_addr_b     = r_base_b + AW'(w_beat);
  assign o_core_enable   = r_en;
  assign o_core_in_valid = r_busy ? r_sparse : SPARSE_DENSE;
  assign o_core_clear    = r_clear;
  assign o_out_valid     = r_ov;

`ifdef CORE_SCHED_PERF_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == ST_FETCH) && r_req && !i_rd_gnt) ||
                   ((r_state == ST_OUT) && r_ov && !i_out_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             r_stall_cnt <= '0;
    else if (w_accept)                        r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_core_tile_sched.sv
module tb_core_tile_sched;
  localparam int DW_CNT = 8, AW = 10, PIPE_LAT = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DW_CNT-1:0] k_tiles = '0;
  logic [AW-1:0] base_a = '0, base_b = '0;
  logic [1:0] sparse_mode = '0;
  logic rd_gnt = 1'b0, out_ready = 1'b0;
  logic busy, done, rd_req, core_enable, core_clear, out_valid;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [1:0] core_in_valid;
`ifdef CORE_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  core_tile_sched #(.DW_CNT(DW_CNT), .AW(AW), .PIPE_LAT(PIPE_LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_tiles(k_tiles),
    .i_base_a(base_a), .i_base_b(base_b), .i_sparse_mode(sparse_mode),
    .o_busy(busy), .o_done(done), .o_rd_req(rd_req),
    .o_rd_addr_a(rd_addr_a), .o_rd_addr_b(rd_addr_b), .i_rd_gnt(rd_gnt),
    .o_core_enable(core_enable), .o_core_in_valid(core_in_valid),
    .o_core_clear(core_clear), .o_out_valid(out_valid), .i_out_ready(out_ready)
`ifdef CORE_SCHED_PERF_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: timestamps of the tile (start cycle, grants, last
  // grant, handshake) determine what every output must be in a cycle.
  bit m_active = 0, m_prev_grant = 0;
  int m_s = 0, m_k = 0, m_grants = 0, m_lastg = 0, m_done_cyc = -10, m_ov_cnt = 0;
  logic [AW-1:0] m_ba = '0, m_bb = '0;
  logic [1:0] m_sp = '0;

  // Observations for the hand-computed scenario expectations.
  int ob_en_cnt, ob_last_en, ob_ov_rise, ob_hs, ob_done_at, ob_req_cnt, ob_clear_cnt, ob_busy_cnt;
  logic [AW-1:0] qa[$], qb[$];

  task automatic clr_obs();
    ob_en_cnt = 0; ob_last_en = -1; ob_ov_rise = -1; ob_hs = -1; ob_done_at = -1;
    ob_req_cnt = 0; ob_clear_cnt = 0; ob_busy_cnt = 0;
    qa.delete(); qb.delete();
  endtask

  always @(negedge clk) begin : cmp
    bit e_busy, e_clear, e_req, e_en, e_ov, e_done;
    logic [1:0] e_inv;
    logic [AW-1:0] e_a, e_b;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
      chk("rst_req", rd_req, 0);     chk("rst_addr_a", rd_addr_a, 0);
      chk("rst_addr_b", rd_addr_b, 0); chk("rst_en", core_enable, 0);
      chk("rst_clear", core_clear, 0); chk("rst_ov", out_valid, 0);
      chk("rst_inv", core_in_valid, 0);
      m_active = 0; m_prev_grant = 0; m_grants = 0; m_done_cyc = -10; m_ov_cnt = 0;
    end else begin
      e_busy  = m_active;
      e_clear = m_active && (cyc == m_s + 1);
      e_req   = m_active && (cyc >= m_s + 2) && (m_grants < m_k);
      e_en    = m_prev_grant;
      e_ov    = m_active && (m_grants == m_k) && (cyc >= m_lastg + 1 + PIPE_LAT);
      e_done  = (cyc == m_done_cyc);
      e_inv   = m_active ? m_sp : 2'd0;
      e_a     = AW'(m_ba + AW'(m_grants));
      e_b     = AW'(m_bb + AW'(m_grants));
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("rd_req", rd_req, e_req);
      chk("core_enable", core_enable, e_en);
      chk("core_clear", core_clear, e_clear);
      chk("out_valid", out_valid, e_ov);
      chk("core_in_valid", core_in_valid, e_inv);
      if (e_req) begin
        chk("rd_addr_a", rd_addr_a, e_a);
        chk("rd_addr_b", rd_addr_b, e_b);
      end
      // observations
      if (core_enable) begin ob_en_cnt++; ob_last_en = cyc; end
      if (out_valid && ob_ov_rise < 0) ob_ov_rise = cyc;
      if (out_valid && out_ready && ob_hs < 0) ob_hs = cyc;
      if (done) ob_done_at = cyc;
      if (rd_req) ob_req_cnt++;
      if (core_clear) ob_clear_cnt++;
      if (busy) ob_busy_cnt++;
      if (rd_req && rd_gnt) begin qa.push_back(rd_addr_a); qb.push_back(rd_addr_b); end
      // advance the model past this cycle's edge
      m_prev_grant = e_req && rd_gnt;
      if (m_prev_grant) begin
        m_grants++;
        if (m_grants == m_k) m_lastg = cyc;
      end
      if (e_ov) m_ov_cnt++;
      if (e_ov && out_ready) begin
        m_active = 0; m_done_cyc = cyc + 1;
      end else if (!m_active && start) begin
        if (k_tiles != 0) begin
          m_active = 1; m_s = cyc; m_k = int'(k_tiles); m_grants = 0; m_ov_cnt = 0;
          m_ba = base_a; m_bb = base_b; m_sp = sparse_mode;
        end else m_done_cyc = cyc + 1;
      end
    end
  end

  // Grant / ready drivers.
  int gnt_mode = 0, rdy_mode = 0, rdy_hold = 0;
  int stl[8];
  initial forever begin
    @(posedge clk); #1;
    case (gnt_mode)
      0: rd_gnt = 1'b1;
      1: rd_gnt = ($urandom_range(0, 2) != 0);
      default: if ((m_grants == 1 || m_grants == 3) && stl[m_grants] < 2) begin
                 rd_gnt = 1'b0; stl[m_grants]++;
               end else rd_gnt = 1'b1;
    endcase
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (m_ov_cnt >= rdy_hold);
    endcase
  end

  int st_cyc;
  task automatic pulse_start(input int k, input int ba, input int bb, input int sp);
    @(posedge clk); #1;
    st_cyc = cyc;
    start = 1'b1; k_tiles = DW_CNT'(k); base_a = AW'(ba); base_b = AW'(bb); sparse_mode = 2'(sp);
    @(posedge clk); #1;
    start = 1'b0;
    // scramble command inputs; the DUT must rely on its latched copy
    k_tiles = DW_CNT'($urandom); base_a = AW'($urandom); base_b = AW'($urandom);
    sparse_mode = 2'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((m_active || cyc <= m_done_cyc) && t < budget) begin @(posedge clk); #1; t++; end
    chk("wait_idle_timeout", (t < budget), 1);
  endtask

  task automatic wait_ov(input int n);
    int t = 0;
    while (m_ov_cnt < n && t < 100) begin @(posedge clk); #1; t++; end
    chk("wait_ov_timeout", (t < 100), 1);
  endtask

  initial begin
    clr_obs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: k=4, grant always
    gnt_mode = 0; rdy_mode = 0; clr_obs();
    pulse_start(4, 'h10, 'h20, 1);
    wait_idle(100);
    chk("s1_en_cnt", ob_en_cnt, 4);
    chk("s1_naddr", qa.size(), 4);
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      chk("s1_addr_a", qa[i], 'h10 + i);
      chk("s1_addr_b", qb[i], 'h20 + i);
    end
    chk("s1_ov_after_en", ob_ov_rise - ob_last_en, 2);
    chk("s1_done_after_hs", ob_done_at - ob_hs, 1);
    chk("s1_clear_cnt", ob_clear_cnt, 1);

    // 2: stalls of 2 cycles on beats 1 and 3
    gnt_mode = 2; foreach (stl[i]) stl[i] = 0; clr_obs();
    pulse_start(4, 'h10, 'h20, 2);
    wait_idle(100);
    chk("s2_en_cnt", ob_en_cnt, 4);
    chk("s2_req_cycles", ob_req_cnt, 8);
    for (int i = 0; i < 4 && i < qa.size(); i++) chk("s2_addr_a", qa[i], 'h10 + i);

    // 3: empty tile
    gnt_mode = 0; clr_obs();
    pulse_start(0, 'h55, 'h66, 3);
    wait_idle(20);
    chk("s3_req", ob_req_cnt, 0);
    chk("s3_clear", ob_clear_cnt, 0);
    chk("s3_ov_seen", (ob_ov_rise >= 0), 0);
    chk("s3_busy", ob_busy_cnt, 0);
    chk("s3_done_at", ob_done_at, st_cyc + 1);

    // 4: back-pressure in OUT, starts during it ignored
    rdy_mode = 2; rdy_hold = 5; clr_obs();
    pulse_start(3, 'h30, 'h31, 1);
    wait_ov(2);
    pulse_start(5, 'h70, 'h71, 2);
    wait_ov(4);
    pulse_start(6, 'h72, 'h73, 3);
    wait_idle(100);
    chk("s4_hold", ob_hs - ob_ov_rise, 5);
    chk("s4_done_after_hs", ob_done_at - ob_hs, 1);
    chk("s4_clear_cnt", ob_clear_cnt, 1);
    chk("s4_en_cnt", ob_en_cnt, 3);

    // 5: reset during beat 2 of 8
    rdy_mode = 0; clr_obs();
    pulse_start(8, 'h40, 'h80, 3);
    begin
      int t = 0;
      while (m_grants < 2 && t < 50) begin @(posedge clk); #1; t++; end
      chk("s5_wait_timeout", (t < 50), 1);
    end
    chk("s5_pre_req", rd_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_busy", busy, 0);
    chk("s5_async_req", rd_req, 0);
    chk("s5_async_addr", rd_addr_a, 0);
    chk("s5_async_inv", core_in_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr_obs();
    pulse_start(3, 'h100, 'h200, 1);
    wait_idle(100);
    chk("s5_clear_cnt", ob_clear_cnt, 1);
    chk("s5_first_addr", (qa.size() > 0) ? qa[0] : 'hFFF, 'h100);
    chk("s5_en_cnt", ob_en_cnt, 3);

    // 6: address wrap
    clr_obs();
    pulse_start(4, 'h3FE, 'h005, 0);
    wait_idle(100);
    chk("s6_naddr", qa.size(), 4);
    if (qa.size() == 4) begin
      chk("s6_a0", qa[0], 'h3FE); chk("s6_a1", qa[1], 'h3FF);
      chk("s6_a2", qa[2], 'h000); chk("s6_a3", qa[3], 'h001);
    end

    // random tiles
    gnt_mode = 1; rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int k;
      k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9);
      pulse_start(k, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3));
      wait_idle(300);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
